// File: rtl/snn_core_streaming_par.sv
// snn_core_streaming_par: lane-parallel spike accumulator streaming grouped potentials; define SNN_CORE_SAT_EN for saturating sums
module snn_core_streaming_par #(
  parameter int IN_NEURONS = 64,
  parameter int OUT_NEURONS = 32,
  parameter int PAR_LANES = 4,
  parameter int TIME_W = 32,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W = 32,
  parameter logic [TIME_W-1:0] T_MAX = 32'h7FFFFFFF,
  parameter logic [TIME_W-1:0] T_MIN = 32'h00010000,
  localparam int G = OUT_NEURONS / PAR_LANES,
  localparam int AW = $clog2(IN_NEURONS) + 1,
  localparam int GW = G > 1 ? $clog2(G) : 1,
  localparam int WAW = IN_NEURONS * G > 1 ? $clog2(IN_NEURONS * G) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clk_enable,
  input  logic                          i_mode,
  input  logic                          i_spike_valid,
  input  logic [TIME_W-1:0]             i_spike_time,
  input  logic [AW-1:0]                 i_spike_addr,
  input  logic                          i_last_spike,
  output logic                          o_spike_ready,
  output logic                          o_result_valid,
  output logic [PAR_LANES*ACC_W-1:0]    o_result_data,
  output logic [GW-1:0]                 o_result_group,
  output logic                          o_last_result,
  input  logic                          i_result_ready,
  output logic [WAW-1:0]                o_wram_addr,
  input  logic [PAR_LANES*WEIGHT_W-1:0] i_wram_rdata,
  output logic [GW-1:0]                 o_pram_addr,
  input  logic [PAR_LANES*ACC_W-1:0]    i_pram_rdata,
  output logic [15:0]                   o_drop_cnt,
  output logic                          o_layer_done
);
  // the spike address carries one extra bit so out-of-range indices are representable
  typedef enum logic [2:0] {IDLE, ACC_RD, ACC_WR, FETCH, FIN_RD, FIN_OUT, DONE} state_t;
  localparam int NW = OUT_NEURONS > 1 ? $clog2(OUT_NEURONS) : 1;
  localparam int PW = TIME_W + 1 + WEIGHT_W;
  localparam int SW = PW + ACC_W + 2;
  localparam logic [AW-1:0] IN_LIM = AW'(IN_NEURONS);
  localparam logic [GW-1:0] GLAST = GW'(G - 1);
  localparam logic signed [TIME_W-1:0] TMAX_S = T_MAX;
  localparam logic signed [TIME_W:0] TMIN_S = {T_MIN[TIME_W-1], T_MIN};
`ifdef SNN_CORE_SAT_EN
  localparam logic signed [SW-1:0] SMAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = ~SMAX;
  function automatic logic [ACC_W-1:0] fit(input logic signed [SW-1:0] v);
    return v > SMAX ? SMAX[ACC_W-1:0] : v < SMIN ? SMIN[ACC_W-1:0] : v[ACC_W-1:0];
  endfunction
`else
  function automatic logic [ACC_W-1:0] fit(input logic signed [SW-1:0] v);
    return v[ACC_W-1:0];
  endfunction
`endif
  state_t state;
  logic [GW-1:0] grp;
  logic [TIME_W-1:0] t_r;
  logic last_r, mode_r, first;
  logic [ACC_W-1:0] pot [OUT_NEURONS];
  logic [PAR_LANES*ACC_W-1:0] acc_flat, fin_flat;
  logic signed [TIME_W:0] diff;
  logic signed [ACC_W-1:0] cur, bias;
  logic signed [WEIGHT_W-1:0] w;
  logic signed [PW-1:0] prod;
  logic xfer, in_range;
  assign xfer = i_spike_valid & o_spike_ready;
  assign in_range = i_spike_addr < IN_LIM;
  // per-lane accumulate and finalize values; "first" means no in-range spike has landed yet, so potentials count as 0
  always_comb begin
    diff = $signed({t_r[TIME_W-1], t_r}) - TMIN_S;
    acc_flat = '0;
    fin_flat = '0;
    cur = '0;
    bias = '0;
    w = '0;
    prod = '0;
    for (int k = 0; k < PAR_LANES; k++) begin
      cur = first ? '0 : pot[NW'(int'(grp) * PAR_LANES + k)];
      w = i_wram_rdata[k*WEIGHT_W +: WEIGHT_W];
      bias = i_pram_rdata[k*ACC_W +: ACC_W];
      prod = PW'(diff) * PW'(w);
      acc_flat[k*ACC_W +: ACC_W] = fit(SW'(cur) + SW'(prod));
      fin_flat[k*ACC_W +: ACC_W] = fit(mode_r ? SW'(cur) + SW'(bias) : SW'(cur) + SW'(TMAX_S) - SW'(bias));
    end
  end
  // control FSM; the bias address runs one group ahead so its registered read data is ready in FIN_RD
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grp <= '0;
      t_r <= '0;
      last_r <= 1'b0;
      mode_r <= 1'b0;
      first <= 1'b0;
      o_spike_ready <= 1'b0;
      o_result_valid <= 1'b0;
      o_result_data <= '0;
      o_result_group <= '0;
      o_last_result <= 1'b0;
      o_wram_addr <= '0;
      o_pram_addr <= '0;
      o_drop_cnt <= '0;
      o_layer_done <= 1'b0;
    end else if (i_clk_enable) begin
      o_layer_done <= 1'b0;
      case (state)
        IDLE, FETCH: if (xfer) begin
          t_r <= i_spike_time;
          last_r <= i_last_spike;
          grp <= '0;
          if (state == IDLE) begin
            mode_r <= i_mode;
            first <= 1'b1;
          end
          if (in_range) begin
            o_wram_addr <= WAW'(int'(i_spike_addr) * G);
            o_spike_ready <= 1'b0;
            state <= ACC_RD;
          end else begin
            o_drop_cnt <= o_drop_cnt + 16'(o_drop_cnt != 16'hFFFF);
            o_spike_ready <= !i_last_spike;
            state <= i_last_spike ? FIN_RD : FETCH;
          end
        end else o_spike_ready <= 1'b1;
        ACC_RD: state <= ACC_WR;
        ACC_WR: if (grp == GLAST) begin
          first <= 1'b0;
          grp <= '0;
          o_spike_ready <= !last_r;
          state <= last_r ? FIN_RD : FETCH;
        end else begin
          grp <= grp + GW'(1);
          o_wram_addr <= o_wram_addr + WAW'(1);
          state <= ACC_RD;
        end
        FIN_RD: begin
          o_result_valid <= 1'b1;
          o_result_data <= fin_flat;
          o_result_group <= grp;
          o_last_result <= grp == GLAST;
          o_pram_addr <= grp == GLAST ? '0 : grp + GW'(1);
          state <= FIN_OUT;
        end
        FIN_OUT: if (i_result_ready) begin
          o_result_valid <= 1'b0;
          o_last_result <= 1'b0;
          if (grp == GLAST) begin
            grp <= '0;
            o_layer_done <= 1'b1;
            state <= DONE;
          end else begin
            grp <= grp + GW'(1);
            state <= FIN_RD;
          end
        end
        DONE: begin
          o_spike_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // potential storage survives reset; the first spike of a stream overwrites it
  always_ff @(posedge clk)
    if (i_clk_enable && state == ACC_WR)
      for (int k = 0; k < PAR_LANES; k++) pot[NW'(int'(grp) * PAR_LANES + k)] <= acc_flat[k*ACC_W +: ACC_W];
endmodule

// File: tb/tb_snn_core_streaming_par.sv
// tb_snn_core_streaming_par: directed streams with a result scoreboard and decoupled monitor
module tb_snn_core_streaming_par;
  logic clk = 0, rst_n = 0, en = 1, mode = 0, sv = 0, last = 0, rr = 1;
  logic [31:0] st = 0;
  logic [2:0] sa = 0;
  logic ready, rv, rlast, done;
  logic [127:0] rdata, pdata;
  logic [0:0] rgrp, paddr;
  logic [2:0] waddr;
  logic [31:0] wdata;
  logic [15:0] drop;
  logic [31:0] wram [8];
  logic [127:0] pram [2];
  int total = 0, bad = 0;
  bit exp_done = 0;
  typedef struct {logic [127:0] d; logic [0:0] g; logic l;} exp_t;
  exp_t q[$];

  snn_core_streaming_par #(.IN_NEURONS(4), .OUT_NEURONS(8), .PAR_LANES(4), .T_MIN(32'd16)) dut (
    .clk(clk), .rst_n(rst_n), .i_clk_enable(en), .i_mode(mode), .i_spike_valid(sv),
    .i_spike_time(st), .i_spike_addr(sa), .i_last_spike(last), .o_spike_ready(ready),
    .o_result_valid(rv), .o_result_data(rdata), .o_result_group(rgrp), .o_last_result(rlast),
    .i_result_ready(rr), .o_wram_addr(waddr), .i_wram_rdata(wdata), .o_pram_addr(paddr),
    .i_pram_rdata(pdata), .o_drop_cnt(drop), .o_layer_done(done));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    wdata <= wram[waddr];
    pdata <= pram[paddr];
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [127:0] lanes(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic push2(input logic [127:0] d0, input logic [127:0] d1);
    q.push_back('{d0, 1'b0, 1'b0});
    q.push_back('{d1, 1'b1, 1'b1});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_done) begin
      chk("layer_done", done, 1);
      exp_done = 0;
    end
    if (rst_n && en && rv && rr) begin
      if (q.size() == 0) chk("unexpected_result", rv, 0);
      else begin
        e = q.pop_front();
        chk("result_data", rdata, e.d);
        chk("result_group", rgrp, e.g);
        chk("last_result", rlast, e.l);
        if (e.l) exp_done = 1;
      end
    end
  end

  task automatic send(input logic [31:0] t, input logic [2:0] a, input logic l, input logic m);
    st = t; sa = a; last = l; mode = m; sv = 1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ready && en) begin
        @(posedge clk); #1;
        sv = 0; last = 0;
        return;
      end
    end
    chk("spike_timeout", 0, 1);
    sv = 0; last = 0;
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rv) return;
    end
    chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) wram[i] = {4{8'd2}};
    pram[0] = '0; pram[1] = '0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_valid", rv, 0);
    chk("rst_drop", drop, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // single spike, output-layer mode: (26-16)*2 = 20 per lane
    push2(lanes(20, 20, 20, 20), lanes(20, 20, 20, 20));
    send(32'd26, 3'd1, 1, 1);
    wait_done();
    // hidden mode, two spikes, bias 5; mode change on second spike ignored
    wram[0] = {4{8'd3}}; wram[1] = {4{8'd3}};
    wram[4] = {4{8'hFF}}; wram[5] = {4{8'hFF}};
    pram[0] = lanes(5, 5, 5, 5); pram[1] = lanes(5, 5, 5, 5);
    push2({4{32'h7FFFFFFC}}, {4{32'h7FFFFFFC}});
    send(32'd18, 3'd0, 0, 0);
    send(32'd20, 3'd2, 1, 1);
    wait_done();
    // distinct lane weights and biases, with back-pressure on group 0
    wram[6] = {8'd4, 8'd3, 8'd2, 8'd1};
    wram[7] = {8'hFC, 8'hFD, 8'hFE, 8'hFF};
    pram[0] = lanes(10, 20, 30, 40); pram[1] = lanes(100, 100, 100, 100);
    push2(lanes(15, 30, 45, 60), lanes(95, 90, 85, 80));
    rr = 0;
    send(32'd17, 3'd3, 0, 1);
    send(32'd20, 3'd3, 1, 1);
    wait_valid();
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("hold_valid", rv, 1);
    chk("hold_data", rdata, lanes(15, 30, 45, 60));
    chk("hold_group", rgrp, 0);
    @(posedge clk); #1 rr = 1;
    wait_done();
    // out-of-range address with last: bias-only results, no weight fetch
    push2(lanes(10, 20, 30, 40), lanes(100, 100, 100, 100));
    send(32'd50, 3'd7, 1, 1);
    wait_done();
    chk("drop_cnt", drop, 1);
    chk("wram_addr_idle", waddr, 3'd7);
    // large product: wraps to 0 by default, saturates with the macro; clock-enable freeze on group 0
    wram[0] = {4{8'd4}}; wram[1] = {4{8'd4}};
    pram[0] = '0; pram[1] = '0;
`ifdef SNN_CORE_SAT_EN
    push2({4{32'h7FFFFFFF}}, {4{32'h7FFFFFFF}});
`else
    push2('0, '0);
`endif
    rr = 0;
    send(32'd16 + 32'h40000000, 3'd0, 1, 1);
    wait_valid();
    @(posedge clk); #1;
    en = 0; rr = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("freeze_valid", rv, 1);
    chk("freeze_group", rgrp, 0);
    @(posedge clk); #1 en = 1;
    wait_done();
    // reset while a result is pending, then a fresh stream
    wram[2] = {4{8'd2}}; wram[3] = {4{8'd2}};
    wram[0] = {4{8'd3}}; wram[1] = {4{8'd3}};
    rr = 0;
    send(32'd26, 3'd1, 1, 1);
    wait_valid();
    @(posedge clk); #1 rst_n = 0;
    #1;
    chk("mid_rst_valid", rv, 0);
    chk("mid_rst_data", rdata, 0);
    chk("mid_rst_drop", drop, 0);
    chk("mid_rst_ready", ready, 0);
    @(posedge clk); #1;
    rst_n = 1; rr = 1;
    push2(lanes(6, 6, 6, 6), lanes(6, 6, 6, 6));
    send(32'd18, 3'd0, 1, 1);
    wait_done();
    @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
